// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and display bundle for the sequential binary-to-BCD converter.
// The master side drives requests and display controls; the slave side is the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  enable;
    logic                  blank_lz;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, bin_in, enable, blank_lz,
        input  busy, done, overflow, bcd_out
    );

    modport slave (
        input  start, bin_in, enable, blank_lz,
        output busy, done, overflow, bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with start/busy/done handshake, overflow flag and leading-zero blanking.
module bin_to_bcd_seq #(
    parameter int         BIN_W  = 16,
    parameter int         DIGITS = 5,
    parameter logic [3:0] BLANK  = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic [BCD_W-1:0] result;
    logic             ovf_q;

    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shifted;
    logic [BIN_W-1:0] bin_shifted;
    logic             carry_out;
    logic             last_shift;
    logic             accept;
    logic             busy_c;
    logic             done_c;
    logic [BCD_W-1:0] bcd_view;

    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // A digit is blanked only while every digit above it is also zero.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = v;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (v[4*k +: 4] != 4'd0) lead = 1'b0;
            if (lead) r[4*k +: 4] = BLANK;
        end
        return r;
    endfunction

    assign bcd_adj    = add3_digits(bcd_sr);
    assign {carry_out, bcd_shifted, bin_shifted} = {bcd_adj, bin_sr, 1'b0};
    assign last_shift = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (last_shift) state_nxt = DONE;
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result and overflow are loaded on the final shift so they are valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            bin_sr  <= bus.bin_in;
            bcd_sr  <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (state == SHIFT) begin
            bin_sr  <= bin_shifted;
            bcd_sr  <= bcd_shifted;
            cnt     <= cnt + 1'b1;
            ovf_acc <= ovf_acc | carry_out;
            if (last_shift) begin
                result <= bcd_shifted;
                ovf_q  <= ovf_acc | carry_out;
            end
        end
    end

    always_comb begin
        bcd_view = '0;
        if (bus.enable) bcd_view = bus.blank_lz ? blank_leading(result) : result;
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_view;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance share stimulus and
// are compared every cycle against an arithmetic model of the conversion.
module tb_bin_to_bcd_seq;
    localparam int BIN_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        enable = 1'b1;
    logic        blank_lz = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(5)) ia ();
    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(4)) ib ();

    assign ia.start = start;    assign ib.start = start;
    assign ia.bin_in = bin_in;  assign ib.bin_in = bin_in;
    assign ia.enable = enable;  assign ib.enable = enable;
    assign ia.blank_lz = blank_lz; assign ib.blank_lz = blank_lz;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(5), .BLANK(4'hF)) dut5 (.clk(clk), .rst(rst), .bus(ia));
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .BLANK(4'hF)) dut4 (.clk(clk), .rst(rst), .bus(ib));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned pow10(input int n);
        int unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Display value expected for a stored binary value on an nd-digit converter.
    function automatic logic [19:0] exp_bcd(input int unsigned v, input int nd, input bit en, input bit blank);
        logic [19:0]  r;
        int unsigned  t;
        r = '0;
        t = v % pow10(nd);
        if (!en) return r;
        for (int k = 0; k < nd; k++) begin
            if (blank && k > 0 && (t / pow10(k)) == 0) r[4*k +: 4] = 4'hF;
            else r[4*k +: 4] = 4'((t / pow10(k)) % 10);
        end
        return r;
    endfunction

    // Reference model: conversion scheduled by edge count, outputs from arithmetic.
    int          edge_no = 0;
    bit          m_pending = 1'b0;
    int          m_done_at = 0;
    int unsigned m_val_in = 0;
    int unsigned m_res = 0;
    bit          m_done = 1'b0;
    bit          m_ovf5 = 1'b0;
    bit          m_ovf4 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
            if (rst) begin
                m_pending = 1'b0;
                m_done    = 1'b0;
                m_res     = 0;
                m_ovf5    = 1'b0;
                m_ovf4    = 1'b0;
            end else begin
                bit acc;
                acc = start && !m_pending;
                if (m_pending && edge_no == m_done_at) begin
                    m_pending = 1'b0;
                    m_done    = 1'b1;
                    m_res     = m_val_in;
                    m_ovf5    = (m_val_in >= 100000);
                    m_ovf4    = (m_val_in >= 10000);
                end else begin
                    m_done = 1'b0;
                end
                if (acc) begin
                    m_pending = 1'b1;
                    m_done_at = edge_no + BIN_W;
                    m_val_in  = int'(bin_in);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) begin
                chk("busy5", ia.busy, m_pending);
                chk("busy4", ib.busy, m_pending);
                chk("done5", ia.done, m_done);
                chk("done4", ib.done, m_done);
                chk("ovf5", ia.overflow, m_ovf5);
                chk("ovf4", ib.overflow, m_ovf4);
                chk("bcd5", ia.bcd_out, exp_bcd(m_res, 5, enable, blank_lz));
                chk("bcd4", ib.bcd_out, 20'(exp_bcd(m_res, 4, enable, blank_lz)));
            end
        end
    end

    // Called at a negedge: pulse start with v and wait (bounded) for done.
    task automatic convert(input logic [15:0] v, output int cyc);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!ia.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!ia.done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        bit saw_done;

        chk("model_65535_d5", 64'(exp_bcd(65535, 5, 1'b1, 1'b0)), 64'h65535);
        chk("model_65535_d4", 64'(exp_bcd(65535, 4, 1'b1, 1'b0)), 64'h5535);
        chk("model_1234_blank", 64'(exp_bcd(1234, 5, 1'b1, 1'b1)), 64'hF1234);
        chk("model_0_blank", 64'(exp_bcd(0, 5, 1'b1, 1'b1)), 64'hFFFF0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;
        chk("rst_busy", ia.busy, 1'b0);
        chk("rst_done", ia.done, 1'b0);
        chk("rst_ovf", ia.overflow, 1'b0);
        chk("rst_bcd", ia.bcd_out, 20'h0);

        // zero value and start-to-done latency
        convert(16'd0, cyc);
        chk("latency", cyc, 17);
        chk("zero_bcd", ia.bcd_out, 20'h00000);
        chk("zero_ovf", ia.overflow, 1'b0);

        // full-scale value and busy duration
        start = 1'b1; bin_in = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; cyc = 0;
        while (!ia.done && cyc < 60) begin
            if (ia.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chk("max_busy_cycles", busy_cnt, 16);
        chk("max_bcd", ia.bcd_out, 20'h65535);
        chk("max_ovf5", ia.overflow, 1'b0);
        chk("max_ovf4", ib.overflow, 1'b1);
        chk("max_bcd4", ib.bcd_out, 16'h5535);

        convert(16'd9999, cyc);
        chk("n9999_ovf4", ib.overflow, 1'b0);
        chk("n9999_bcd4", ib.bcd_out, 16'h9999);

        // blanking and enable
        blank_lz = 1'b1;
        convert(16'd1234, cyc);
        chk("blank_1234", ia.bcd_out, 20'hF1234);
        @(negedge clk);
        enable = 1'b0;
        #1;
        chk("enable_off", ia.bcd_out, 20'h0);
        @(negedge clk);
        enable = 1'b1;
        convert(16'd0, cyc);
        chk("blank_zero", ia.bcd_out, 20'hFFFF0);
        blank_lz = 1'b0;

        // start while busy ignored, start in done cycle accepted
        start = 1'b1; bin_in = 16'd42;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; bin_in = 16'd999;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!ia.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore_busy_bcd", ia.bcd_out, 20'h00042);
        convert(16'd777, cyc);
        chk("back_to_back_latency", cyc, 17);
        chk("back_to_back_bcd", ia.bcd_out, 20'h00777);

        // reset mid-conversion
        start = 1'b1; bin_in = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", ia.busy, 1'b0);
        chk("abort_bcd", ia.bcd_out, 20'h0);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ia.done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 1'b0);

        // randomized conversions with random interference while busy
        for (int it = 0; it < 200; it++) begin
            logic [15:0] v;
            case ($urandom_range(0, 7))
                0: v = 16'hFFFF;
                1: v = 16'(9999 + $urandom_range(0, 2));
                2: v = 16'($urandom_range(0, 15));
                default: v = 16'($urandom_range(0, 65535));
            endcase
            enable   = ($urandom_range(0, 4) != 0);
            blank_lz = $urandom_range(0, 1) != 0;
            start  = 1'b1;
            bin_in = v;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (!ia.done && cyc < 60) begin
                start    = ($urandom_range(0, 5) == 0);
                bin_in   = 16'($urandom_range(0, 65535));
                enable   = ($urandom_range(0, 4) != 0);
                blank_lz = $urandom_range(0, 1) != 0;
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            if (!ia.done) chk("rand_done_timeout", 64'd0, 64'd1);
        end

        repeat (40) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before 2000000");
        $fatal(1, "timeout");
    end
endmodule
